// File: rtl/minibyte_pkg.sv
// Shared types and defaults for the minibyte memory arbiter.
// Grant ids, FSM states and the captured-access bundle live here.
package minibyte_pkg;

  localparam logic [7:0] ROM_TOP_DEF  = 8'h3F;
  localparam logic [7:0] OUT_ADDR_DEF = 8'h40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_t;

  typedef struct packed {
    gnt_t       who;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  function automatic logic is_prot(
    input logic       we,
    input logic [7:0] addr,
    input logic [7:0] top
  );
    return we && (addr <= top);
  endfunction

endpackage

// File: rtl/minibyte_rr_arb.sv
// Two-way round-robin picker between CPU and debug host.
// A locked debug owner keeps the grant until dbg_lock drops.
module minibyte_rr_arb
  import minibyte_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic dbg_lock,
  input  logic grant_en,
  input  logic resp_dbg,
  output logic any,
  output gnt_t winner
);

  gnt_t last_q;
  logic lock_q;
  logic hold;
  logic cpu_ok;

  // Lock is armed by a dbg ack cycle and lives while dbg_lock stays high.
  always_comb begin
    hold   = dbg_lock & (lock_q | resp_dbg);
    cpu_ok = cpu_req & ~hold;
    any    = cpu_ok | dbg_req;
  end

  // Tie goes to whoever was not granted last.
  always_comb begin
    winner = GNT_DBG;
    unique case (1'b1)
      cpu_ok & dbg_req:
        winner = (last_q == GNT_CPU) ? GNT_DBG : GNT_CPU;
      cpu_ok & ~dbg_req:
        winner = GNT_CPU;
      default:
        winner = GNT_DBG;
    endcase
  end

  // Remember the last grant and the lock state.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_DBG;
      lock_q <= 1'b0;
    end else begin
      lock_q <= hold;
      if (grant_en) last_q <= winner;
    end
  end

endmodule

// File: rtl/minibyte_mem_arbiter.sv
// Shares one memory port between CPU and debug host.
// Each access takes ISSUE then RESP; ROM writes are blocked.
module minibyte_mem_arbiter
  import minibyte_pkg::*;
#(
  parameter logic [7:0] ROM_TOP  = ROM_TOP_DEF,
  parameter logic [7:0] OUT_ADDR = OUT_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic       dbg_lock,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_ack,
  output logic [7:0] dbg_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [7:0] out_port,
  output logic       wp_err
);

  state_t     state_q;
  state_t     state_d;
  acc_t       acc_q;
  acc_t       pick;
  gnt_t       winner;
  logic       any;
  logic       grant;
  logic       resp_dbg;
  logic       prot;
  logic [7:0] resp_data;
  logic [7:0] out_q;
  logic       wp_q;
  logic [7:0] cpu_rd_q;
  logic [7:0] dbg_rd_q;

  assign grant    = any & (state_q != ISSUE);
  assign resp_dbg = (state_q == RESP) & (acc_q.who == GNT_DBG);
  assign prot     = is_prot(acc_q.we, acc_q.addr, ROM_TOP);

  minibyte_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .dbg_lock (dbg_lock),
    .grant_en (grant),
    .resp_dbg (resp_dbg),
    .any      (any),
    .winner   (winner)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: an access is always ISSUE then RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = any ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the winning requester's fields.
  always_comb begin
    pick = '0;
    pick.who = winner;
    if (winner == GNT_CPU) begin
      pick.we    = cpu_we;
      pick.addr  = cpu_addr;
      pick.wdata = cpu_wdata;
    end else begin
      pick.we    = dbg_we;
      pick.addr  = dbg_addr;
      pick.wdata = dbg_wdata;
    end
  end

  // Capture the granted access; held through RESP.
  always_ff @(posedge clk) begin
    if (rst)        acc_q <= '0;
    else if (grant) acc_q <= pick;
  end

  // Output port load and sticky protect flag, both at end of ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 8'h00;
      wp_q  <= 1'b0;
    end else if (state_q == ISSUE) begin
      if (prot) wp_q <= 1'b1;
      if (acc_q.we && !prot && acc_q.addr == OUT_ADDR)
        out_q <= acc_q.wdata;
    end
  end

  // Data returned in RESP for the captured access.
  always_comb begin
    resp_data = 8'h00;
    if (!acc_q.we)
      resp_data = (acc_q.addr == OUT_ADDR) ? out_q : mem_rdata;
  end

  // Hold each requester's last read data between acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rd_q <= 8'h00;
      dbg_rd_q <= 8'h00;
    end else if (state_q == RESP) begin
      if (acc_q.who == GNT_CPU) cpu_rd_q <= resp_data;
      else                      dbg_rd_q <= resp_data;
    end
  end

  // Outputs decoded from state; everything forced low under reset.
  always_comb begin
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    cpu_rdata = 8'h00;
    dbg_rdata = 8'h00;
    out_port  = 8'h00;
    wp_err    = 1'b0;
    if (!rst) begin
      mem_addr  = acc_q.addr;
      mem_wdata = acc_q.wdata;
      cpu_rdata = cpu_rd_q;
      dbg_rdata = dbg_rd_q;
      out_port  = out_q;
      wp_err    = wp_q;
      unique case (state_q)
        ISSUE: begin
          mem_en = ~prot;
          mem_we = acc_q.we & ~prot;
        end
        RESP: begin
          if (acc_q.who == GNT_CPU) begin
            cpu_ack   = 1'b1;
            cpu_rdata = resp_data;
          end else begin
            dbg_ack   = 1'b1;
            dbg_rdata = resp_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minibyte_mem_arbiter.sv
// Bench for minibyte_mem_arbiter: transaction model plus
// directed scenarios and randomized traffic.
module tb_minibyte_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       dbg_req, dbg_we, dbg_lock;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       dbg_ack;
  logic [7:0] dbg_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] out_port;
  logic       wp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  minibyte_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_lock  (dbg_lock),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .out_port  (out_port),
    .wp_err    (wp_err)
  );

  // bench memory (driven by DUT) and independent model memory
  logic [7:0] bmem [256];
  logic [7:0] mm   [256];

  // transaction model: ph 0 none, 1 strobe cycle, 2 ack cycle
  int         ph, who, last;
  bit         locked;
  logic       mwe;
  logic [7:0] maddr, mwd, exp_d;
  logic [7:0] mout, hcpu, hdbg;
  bit         mwp;

  task automatic chk(input string nm, input logic [7:0] a,
                     input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    chk(nm, {7'd0, a}, {7'd0, e});
  endtask

  task automatic chk_seq(input string nm, input string a,
                         input string e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %s want %s", nm, a, e);
    end
  endtask

  task automatic model_step();
    int  old;
    bit  hold, ce;
    if (rst) begin
      ph = 0; last = 1; locked = 0;
      mout = 0; mwp = 0; hcpu = 0; hdbg = 0;
      return;
    end
    old = ph;
    if (old == 2 && who == 1) locked = 1;
    hold   = locked && dbg_lock;
    locked = hold;
    if (old == 1) begin
      if (mwe) exp_d = 8'h00;
      else     exp_d = (maddr == 8'h40) ? mout : mm[maddr];
      if (mwe && maddr <= 8'h3F) mwp = 1;
      else if (mwe) begin
        mm[maddr] = mwd;
        if (maddr == 8'h40) mout = mwd;
      end
      ph = 2;
    end else begin
      if (old == 2) begin
        if (who == 0) hcpu = exp_d;
        else          hdbg = exp_d;
      end
      ce = cpu_req && !hold;
      if (ce || dbg_req) begin
        if (ce && dbg_req) who = (last == 0) ? 1 : 0;
        else               who = ce ? 0 : 1;
        last  = who;
        mwe   = (who == 0) ? cpu_we    : dbg_we;
        maddr = (who == 0) ? cpu_addr  : dbg_addr;
        mwd   = (who == 0) ? cpu_wdata : dbg_wdata;
        ph    = 1;
      end else begin
        ph = 0;
      end
    end
  endtask

  task automatic compare();
    bit e_en, e_ca, e_da;
    e_en = (ph == 1) && !(mwe && maddr <= 8'h3F);
    e_ca = (ph == 2) && (who == 0);
    e_da = (ph == 2) && (who == 1);
    chk1("mem_en", mem_en, e_en);
    chk1("mem_we", mem_we, e_en && mwe);
    if (e_en) begin
      chk("mem_addr", mem_addr, maddr);
      chk("mem_wdata", mem_wdata, mwd);
    end
    chk1("cpu_ack", cpu_ack, e_ca);
    chk1("dbg_ack", dbg_ack, e_da);
    chk("cpu_rdata", cpu_rdata, e_ca ? exp_d : hcpu);
    chk("dbg_rdata", dbg_rdata, e_da ? exp_d : hdbg);
    chk("out_port", out_port, mout);
    chk1("wp_err", wp_err, mwp);
  endtask

  task automatic tick();
    @(posedge clk);
    if (mem_en && mem_we) bmem[mem_addr] = mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? bmem[mem_addr]
                                     : 8'($urandom);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_in();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0;
    dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  function automatic string ackc();
    if (cpu_ack && dbg_ack) return "X";
    if (cpu_ack) return "C";
    if (dbg_ack) return "D";
    return "-";
  endfunction

  function automatic logic [7:0] raddr();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 8'h40;
    if (k == 1) return 8'($urandom_range(0, 63));
    return 8'($urandom);
  endfunction

  initial begin
    string seq;
    for (int i = 0; i < 256; i++) begin
      bmem[i] = 8'(i) ^ 8'h04;
      mm[i]   = 8'(i) ^ 8'h04;
    end
    mem_rdata = 8'h00;
    ph = 0; who = 0; last = 1; locked = 0;
    mwe = 0; maddr = 0; mwd = 0; exp_d = 0;
    mout = 0; hcpu = 0; hdbg = 0; mwp = 0;
    idle_in();
    do_reset();
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk("rst_out_port", out_port, 8'h00);
    chk1("rst_wp_err", wp_err, 1'b0);

    // single CPU read of 0x05 (memory holds 0x01)
    cpu_req = 1; cpu_addr = 8'h05;
    tick();
    cpu_req = 0;
    chk1("rd_mem_en_c1", mem_en, 1'b1);
    chk("rd_mem_addr_c1", mem_addr, 8'h05);
    tick();
    chk1("rd_ack_c2", cpu_ack, 1'b1);
    chk("rd_data_c2", cpu_rdata, 8'h01);
    tick();
    chk("rd_data_hold", cpu_rdata, 8'h01);

    // both requesting after reset: strict alternation from CPU
    do_reset();
    cpu_req = 1; cpu_addr = 8'h20;
    dbg_req = 1; dbg_addr = 8'h30;
    seq = "";
    for (int i = 0; i < 8; i++) begin
      tick();
      seq = {seq, ackc()};
    end
    chk_seq("rr_order", seq, "-C-D-C-D");
    idle_in();
    tick();

    // protected write: no strobe, still acked, sticky flag
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hAA;
    tick();
    idle_in();
    chk1("wp_mem_en", mem_en, 1'b0);
    tick();
    chk1("wp_ack", cpu_ack, 1'b1);
    chk1("wp_flag", wp_err, 1'b1);
    tick();
    tick();
    chk1("wp_sticky", wp_err, 1'b1);

    // dbg writes the output port, CPU reads it back
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 8'h5A;
    tick();
    idle_in();
    chk1("op_mem_we", mem_we, 1'b1);
    chk("op_mem_wdata", mem_wdata, 8'h5A);
    tick();
    chk1("op_dbg_ack", dbg_ack, 1'b1);
    chk("op_out_port", out_port, 8'h5A);
    cpu_req = 1; cpu_addr = 8'h40;
    tick();
    cpu_req = 0;
    tick();
    chk("op_cpu_rdata", cpu_rdata, 8'h5A);

    // dbg lock keeps CPU out until the lock drops
    cpu_req = 1; cpu_addr = 8'h20;
    dbg_req = 1; dbg_addr = 8'h30; dbg_lock = 1;
    seq = "";
    for (int i = 0; i < 8; i++) begin
      tick();
      seq = {seq, ackc()};
      if (i == 5) dbg_lock = 0;
    end
    chk_seq("lock_order", seq, "-D-D-D-C");
    idle_in();
    tick();

    // reset during the strobe cycle of an output-port write
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 8'h77;
    tick();
    idle_in();
    chk1("abort_issue", mem_en, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk1("abort_no_ack", dbg_ack, 1'b0);
    chk("abort_out_port", out_port, 8'h00);
    chk1("abort_idle", mem_en, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = raddr();
      cpu_wdata = 8'($urandom);
      dbg_req   = ($urandom_range(0, 2) == 0);
      dbg_we    = $urandom_range(0, 1) == 1;
      dbg_lock  = ($urandom_range(0, 3) != 0);
      dbg_addr  = raddr();
      dbg_wdata = 8'($urandom);
      tick();
    end
    rst = 0;
    idle_in();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minibyte_mem_arbiter.md
MINIBYTE_MEM_ARBITER -- requirements
Module: minibyte_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ROM_TOP, 8'h3F, highest write-protected program address; OUT_ADDR, 8'h40, output-port register address.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cpu_req/cpu_we  input  1/1  CPU access request, write when high.
REQ-005 cpu_addr/cpu_wdata  input  8/8  CPU address and write data.
REQ-006 cpu_ack  output  1  one-cycle completion pulse to the CPU.
REQ-007 cpu_rdata  output  8  CPU read data, valid in the cpu_ack cycle.
REQ-008 dbg_req/dbg_we/dbg_lock  input  1/1/1  debug-host request, write, and exclusive-hold request.
REQ-009 dbg_addr/dbg_wdata  input  8/8  debug-host address and write data.
REQ-010 dbg_ack/dbg_rdata  output  1/8  debug-host completion pulse and read data.
REQ-011 mem_en/mem_we  output  1/1  shared memory strobe and write enable.
REQ-012 mem_addr/mem_wdata  output  8/8  shared memory address and write data.
REQ-013 mem_rdata  input  8  memory read data, valid the cycle after a mem_en read.
REQ-014 out_port  output  8  registered output-port value.
REQ-015 wp_err  output  1  sticky write-protect violation flag.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE when any req is high, ISSUE->RESP always, RESP->ISSUE if any req is pending, else RESP->IDLE.
REQ-017 The winner SHALL be registered on entry to ISSUE; its addr/we/wdata are captured then and held internally through RESP.
REQ-018 mem_en SHALL be high only in ISSUE, with mem_addr/mem_we/mem_wdata from the captured request.
REQ-019 The winner's ack SHALL pulse high exactly in RESP; the other ack stays low; latency from req sampled in IDLE to ack is 2 cycles.
REQ-020 Back-to-back throughput SHALL be one access per 2 cycles (ISSUE, RESP, ISSUE, ...).
REQ-021 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; a lone requester always wins.
REQ-022 When dbg is granted and dbg_lock is high in RESP, the next grant SHALL go to dbg only; the CPU waits until dbg_lock is low.
REQ-023 A write with addr <= ROM_TOP SHALL keep mem_en low, still ack normally, and set wp_err.
REQ-024 A write to OUT_ADDR SHALL load out_port in ISSUE and also write memory.
REQ-025 A read of OUT_ADDR SHALL return out_port, not mem_rdata.
REQ-026 Read data SHALL be mem_rdata (or out_port) in RESP; writes return 8'h00; each rdata holds its value between acks.
REQ-027 A requester dropping req before its ack is illegal; the arbiter SHALL complete the captured access regardless.

Reset
REQ-028 While rst is high: state=IDLE; cpu_ack=dbg_ack=mem_en=mem_we=0; mem_addr=mem_wdata=0; cpu_rdata=dbg_rdata=out_port=0; wp_err=0; last_grant=DBG, so the CPU wins the first tie.
REQ-029 rst asserted during ISSUE or RESP SHALL abort the access with no ack and no out_port update.

Structure
REQ-030 Shared package minibyte_pkg SHALL hold the state enum, the grant-id type (CPU/DBG), and the ROM_TOP/OUT_ADDR defaults.
REQ-031 The 2-way round-robin picker, including lock handling, SHALL be a sub-module minibyte_rr_arb.

Verification
REQ-032 CPU reads 8'h05 with mem_rdata=8'h01 -> mem_en in cycle 1, cpu_ack and cpu_rdata=8'h01 in cycle 2.
REQ-033 cpu_req and dbg_req both held for 4 accesses after reset -> grant order CPU, DBG, CPU, DBG, with acks every 2 cycles.
REQ-034 dbg_lock=1 with both requesting for 3 dbg accesses -> no cpu_ack; after lock drops, next grant goes to CPU.
REQ-035 CPU writes 8'hAA to 8'h10 -> mem_en stays 0, cpu_ack pulses, wp_err=1 until rst.
REQ-036 dbg writes 8'h5A to 8'h40, then CPU reads 8'h40 -> out_port=8'h5A, mem write seen, cpu_rdata=8'h5A.
REQ-037 rst pulsed during ISSUE of a write to 8'h40 -> no ack, out_port=0, state IDLE next cycle.
